// File: rtl/load_store_unit_if.sv
// Request and data-memory signal bundle for the load/store unit.
// The slave modport is the unit's view; the master modport drives it.
interface load_store_unit_if #(
    parameter int DATA_WIDTH = 64
) ();
    logic                  i_req_valid;
    logic                  o_req_ready;
    logic                  i_is_store;
    logic [2:0]            i_funct3;
    logic [DATA_WIDTH-1:0] i_addr;
    logic [DATA_WIDTH-1:0] i_store_data;
    logic                  o_done;
    logic [DATA_WIDTH-1:0] o_load_data;
    logic                  o_misaligned;
    logic                  o_illegal;
    logic                  o_mem_req;
    logic                  o_mem_we;
    logic [DATA_WIDTH-1:0] o_mem_addr;
    logic [DATA_WIDTH-1:0] o_mem_wdata;
    logic [7:0]            o_mem_be;
    logic                  i_mem_ack;
    logic [DATA_WIDTH-1:0] i_mem_rdata;

    modport slave (
        input  i_req_valid, i_is_store, i_funct3, i_addr, i_store_data,
        input  i_mem_ack, i_mem_rdata,
        output o_req_ready, o_done, o_load_data, o_misaligned, o_illegal,
        output o_mem_req, o_mem_we, o_mem_addr, o_mem_wdata, o_mem_be
    );

    modport master (
        output i_req_valid, i_is_store, i_funct3, i_addr, i_store_data,
        output i_mem_ack, i_mem_rdata,
        input  o_req_ready, o_done, o_load_data, o_misaligned, o_illegal,
        input  o_mem_req, o_mem_we, o_mem_addr, o_mem_wdata, o_mem_be
    );
endinterface

// File: rtl/load_store_unit.sv
// Memory stage: one aligned load/store per request over a req/ack port,
// with byte-lane alignment, sign/zero extension and fault reporting.
module load_store_unit #(
    parameter int DATA_WIDTH = 64
) (
    input logic                i_clk,
    input logic                i_rst_n,
    load_store_unit_if.slave   bus
);
    typedef enum logic [1:0] {IDLE, MEM, DONE} state_t;

    state_t                r_state;
    logic                  r_req_ready;
    logic                  r_done;
    logic                  r_misaligned;
    logic                  r_illegal;
    logic                  r_mem_req;
    logic                  r_mem_we;
    logic [DATA_WIDTH-1:0] r_mem_addr;
    logic [DATA_WIDTH-1:0] r_mem_wdata;
    logic [7:0]            r_mem_be;
    logic [DATA_WIDTH-1:0] r_load_data;
    logic [2:0]            r_funct3;
    logic [2:0]            r_addr_lo;

    logic                  w_illegal;
    logic                  w_misaligned;
    logic [7:0]            w_size_mask;
    logic [7:0]            w_be;
    logic [DATA_WIDTH-1:0] w_wdata;
    logic [DATA_WIDTH-1:0] w_shifted;
    logic [DATA_WIDTH-1:0] w_extended;
    logic                  w_sext;

    // Request decode works on the live inputs so the fault/MEM decision is made in the accept cycle.
    always_comb begin
        w_illegal = bus.i_is_store ? bus.i_funct3[2] : (bus.i_funct3 == 3'b111);
        case (bus.i_funct3[1:0])
            2'b00:   begin w_size_mask = 8'h01; w_misaligned = 1'b0;                end
            2'b01:   begin w_size_mask = 8'h03; w_misaligned = bus.i_addr[0];        end
            2'b10:   begin w_size_mask = 8'h0F; w_misaligned = |bus.i_addr[1:0];     end
            default: begin w_size_mask = 8'hFF; w_misaligned = |bus.i_addr[2:0];     end
        endcase
        w_be    = w_size_mask << bus.i_addr[2:0];
        w_wdata = bus.i_store_data << {bus.i_addr[2:0], 3'b000};
    end

    // Load extraction uses the captured size/offset since the request inputs are no longer held.
    always_comb begin
        w_shifted = bus.i_mem_rdata >> {r_addr_lo, 3'b000};
        w_sext    = ~r_funct3[2];
        case (r_funct3[1:0])
            2'b00:   w_extended = {{(DATA_WIDTH-8){w_sext & w_shifted[7]}},   w_shifted[7:0]};
            2'b01:   w_extended = {{(DATA_WIDTH-16){w_sext & w_shifted[15]}}, w_shifted[15:0]};
            2'b10:   w_extended = {{(DATA_WIDTH-32){w_sext & w_shifted[31]}}, w_shifted[31:0]};
            default: w_extended = w_shifted;
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            r_state      <= IDLE;
            r_req_ready  <= 1'b0;
            r_done       <= 1'b0;
            r_misaligned <= 1'b0;
            r_illegal    <= 1'b0;
            r_mem_req    <= 1'b0;
            r_mem_we     <= 1'b0;
            r_mem_addr   <= '0;
            r_mem_wdata  <= '0;
            r_mem_be     <= '0;
            r_load_data  <= '0;
            r_funct3     <= '0;
            r_addr_lo    <= '0;
        end else begin
            case (r_state)
                IDLE: begin
                    r_req_ready <= 1'b1;
                    if (bus.i_req_valid && r_req_ready) begin
                        r_req_ready <= 1'b0;
                        r_funct3    <= bus.i_funct3;
                        r_addr_lo   <= bus.i_addr[2:0];
                        if (w_illegal || w_misaligned) begin
                            r_state      <= DONE;
                            r_done       <= 1'b1;
                            r_illegal    <= w_illegal;
                            r_misaligned <= ~w_illegal & w_misaligned;
                        end else begin
                            r_state     <= MEM;
                            r_mem_req   <= 1'b1;
                            r_mem_we    <= bus.i_is_store;
                            r_mem_addr  <= {bus.i_addr[DATA_WIDTH-1:3], 3'b000};
                            r_mem_wdata <= w_wdata;
                            r_mem_be    <= bus.i_is_store ? w_be : 8'h00;
                        end
                    end
                end
                MEM: begin
                    if (bus.i_mem_ack) begin
                        r_state   <= DONE;
                        r_done    <= 1'b1;
                        r_mem_req <= 1'b0;
                        r_mem_we  <= 1'b0;
                        r_mem_be  <= '0;
                        if (!r_mem_we) r_load_data <= w_extended;
                    end
                end
                DONE: begin
                    r_state      <= IDLE;
                    r_done       <= 1'b0;
                    r_illegal    <= 1'b0;
                    r_misaligned <= 1'b0;
                    r_req_ready  <= 1'b1;
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign bus.o_req_ready  = r_req_ready;
    assign bus.o_done       = r_done;
    assign bus.o_load_data  = r_load_data;
    assign bus.o_misaligned = r_misaligned;
    assign bus.o_illegal    = r_illegal;
    assign bus.o_mem_req    = r_mem_req;
    assign bus.o_mem_we     = r_mem_we;
    assign bus.o_mem_addr   = r_mem_addr;
    assign bus.o_mem_wdata  = r_mem_wdata;
    assign bus.o_mem_be     = r_mem_be;
endmodule

// File: tb/tb_load_store_unit.sv
// Scoreboard bench for load_store_unit: expectations are queued per request
// and compared when the access completes.
module tb_load_store_unit;
    logic clk;
    logic rst_n;

    load_store_unit_if #(.DATA_WIDTH(64)) bus ();

    load_store_unit #(.DATA_WIDTH(64)) dut (
        .i_clk   (clk),
        .i_rst_n (rst_n),
        .bus     (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [63:0] ld;
        logic        mis;
        logic        ill;
        int unsigned lat;
    } exp_t;

    exp_t exp_q[$];
    int unsigned checks;
    int unsigned fails;

    logic        ob_done;
    logic        ob_pulse_ok;
    int unsigned ob_lat;
    logic        ob_saw_req;
    logic        ob_stable;
    logic        ob_we;
    logic [63:0] ob_addr;
    logic [63:0] ob_wdata;
    logic [7:0]  ob_be;
    logic [63:0] ob_ld;
    logic        ob_mis;
    logic        ob_ill;

    // Drives one request, plays the memory with 'delay' no-ack cycles, records what the DUT did.
    task automatic issue(input logic st, input logic [2:0] f3, input logic [63:0] a,
                         input logic [63:0] sd, input logic [63:0] rd, input int unsigned delay);
        int unsigned n;
        int unsigned mem_cycles;
        ob_done = 1'b0; ob_pulse_ok = 1'b0; ob_lat = 0; ob_saw_req = 1'b0; ob_stable = 1'b1;
        ob_we = 1'b0; ob_addr = '0; ob_wdata = '0; ob_be = '0; ob_ld = '0; ob_mis = 1'b0; ob_ill = 1'b0;
        @(negedge clk);
        n = 0;
        while (!bus.o_req_ready && n < 20) begin @(negedge clk); n++; end
        if (!bus.o_req_ready) return;
        bus.i_req_valid = 1'b1; bus.i_is_store = st; bus.i_funct3 = f3;
        bus.i_addr = a; bus.i_store_data = sd;
        @(posedge clk); #1;
        bus.i_req_valid = 1'b0;
        mem_cycles = 0;
        for (int c = 1; c <= 30 && !ob_done; c++) begin
            @(negedge clk);
            if (bus.o_mem_req) begin
                if (!ob_saw_req) begin
                    ob_we = bus.o_mem_we; ob_addr = bus.o_mem_addr;
                    ob_wdata = bus.o_mem_wdata; ob_be = bus.o_mem_be;
                end else if (ob_we !== bus.o_mem_we || ob_addr !== bus.o_mem_addr ||
                             ob_wdata !== bus.o_mem_wdata || ob_be !== bus.o_mem_be) begin
                    ob_stable = 1'b0;
                end
                ob_saw_req = 1'b1;
                bus.i_mem_ack = (mem_cycles == delay);
                bus.i_mem_rdata = rd;
                mem_cycles++;
            end else begin
                bus.i_mem_ack = 1'b0;
            end
            if (bus.o_done) begin
                ob_done = 1'b1; ob_lat = c;
                ob_ld = bus.o_load_data; ob_mis = bus.o_misaligned; ob_ill = bus.o_illegal;
            end
        end
        bus.i_mem_ack = 1'b0;
        @(negedge clk);
        ob_pulse_ok = ob_done && !bus.o_done;
    endtask

    task automatic test_reset;
        rst_n = 1'b0;
        bus.i_req_valid = 1'b0; bus.i_is_store = 1'b0; bus.i_funct3 = '0; bus.i_addr = '0;
        bus.i_store_data = '0; bus.i_mem_ack = 1'b0; bus.i_mem_rdata = '0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        checks++;
        if ({bus.o_req_ready, bus.o_done, bus.o_misaligned, bus.o_illegal, bus.o_mem_req, bus.o_mem_we} !== 6'b0) begin
            fails++; $display("FAIL reset_ctrl: got %b want 000000", {bus.o_req_ready, bus.o_done,
                     bus.o_misaligned, bus.o_illegal, bus.o_mem_req, bus.o_mem_we});
        end
        checks++;
        if (bus.o_load_data !== 64'h0 || bus.o_mem_addr !== 64'h0 || bus.o_mem_wdata !== 64'h0 || bus.o_mem_be !== 8'h0) begin
            fails++; $display("FAIL reset_data: ld=%h addr=%h wdata=%h be=%h want all 0",
                     bus.o_load_data, bus.o_mem_addr, bus.o_mem_wdata, bus.o_mem_be);
        end
        rst_n = 1'b1;
        @(negedge clk);
        checks++;
        if (bus.o_req_ready !== 1'b1) begin
            fails++; $display("FAIL reset_ready: got %b want 1", bus.o_req_ready);
        end
    endtask

    task automatic test_ld;
        exp_t e;
        exp_q.push_back('{ld: 64'h8877665544332211, mis: 1'b0, ill: 1'b0, lat: 2});
        issue(1'b0, 3'b011, 64'h1000, 64'h0, 64'h8877665544332211, 0);
        e = exp_q.pop_front();
        checks++;
        if (ob_done !== 1'b1 || ob_lat !== e.lat) begin
            fails++; $display("FAIL ld_latency: done=%b lat=%0d want done=1 lat=%0d", ob_done, ob_lat, e.lat);
        end
        checks++;
        if (ob_we !== 1'b0 || ob_be !== 8'h00 || ob_addr !== 64'h1000) begin
            fails++; $display("FAIL ld_bus: we=%b be=%h addr=%h want we=0 be=00 addr=1000", ob_we, ob_be, ob_addr);
        end
        checks++;
        if (ob_ld !== e.ld || ob_mis !== e.mis || ob_ill !== e.ill) begin
            fails++; $display("FAIL ld_data: got %h mis=%b ill=%b want %h", ob_ld, ob_mis, ob_ill, e.ld);
        end
        checks++;
        if (ob_pulse_ok !== 1'b1) begin
            fails++; $display("FAIL ld_pulse: o_done not a single-cycle pulse");
        end
    endtask

    task automatic test_byte_ext;
        exp_t e;
        exp_q.push_back('{ld: 64'hFFFFFFFFFFFFFF80, mis: 1'b0, ill: 1'b0, lat: 2});
        exp_q.push_back('{ld: 64'h0000000000000080, mis: 1'b0, ill: 1'b0, lat: 2});
        for (int k = 0; k < 2; k++) begin
            issue(1'b0, (k == 0) ? 3'b000 : 3'b100, 64'h1003, 64'h0, 64'hAABBCCDD80112233, 0);
            e = exp_q.pop_front();
            checks++;
            if (ob_done !== 1'b1 || ob_ld !== e.ld || ob_lat !== e.lat) begin
                fails++; $display("FAIL byte_ext_%0d: got %h lat=%0d want %h lat=%0d", k, ob_ld, ob_lat, e.ld, e.lat);
            end
        end
    endtask

    task automatic test_store_wait;
        exp_t e;
        exp_q.push_back('{ld: 64'h0000000000000080, mis: 1'b0, ill: 1'b0, lat: 5});
        issue(1'b1, 3'b001, 64'h2006, 64'hABCD, 64'hFFFFFFFFFFFFFFFF, 3);
        e = exp_q.pop_front();
        checks++;
        if (ob_we !== 1'b1 || ob_be !== 8'hC0 || ob_addr !== 64'h2000 || ob_wdata !== 64'hABCD000000000000) begin
            fails++; $display("FAIL sh_bus: we=%b be=%h addr=%h wdata=%h want 1 c0 2000 abcd000000000000",
                     ob_we, ob_be, ob_addr, ob_wdata);
        end
        checks++;
        if (ob_stable !== 1'b1) begin
            fails++; $display("FAIL sh_stable: request changed during ack wait");
        end
        checks++;
        if (ob_done !== 1'b1 || ob_lat !== e.lat) begin
            fails++; $display("FAIL sh_latency: done=%b lat=%0d want 1 %0d", ob_done, ob_lat, e.lat);
        end
        checks++;
        if (ob_ld !== e.ld) begin
            fails++; $display("FAIL sh_ld_hold: got %h want %h", ob_ld, e.ld);
        end
    endtask

    task automatic test_faults;
        exp_t e;
        logic [2:0] f3s [3] = '{3'b010, 3'b111, 3'b011};
        logic       sts [3] = '{1'b0, 1'b0, 1'b1};
        exp_q.push_back('{ld: 64'h80, mis: 1'b1, ill: 1'b0, lat: 1});
        exp_q.push_back('{ld: 64'h80, mis: 1'b0, ill: 1'b1, lat: 1});
        exp_q.push_back('{ld: 64'h80, mis: 1'b1, ill: 1'b0, lat: 1});
        for (int k = 0; k < 3; k++) begin
            issue(sts[k], f3s[k], 64'h3002, 64'h1234, 64'hDEADBEEFDEADBEEF, 0);
            e = exp_q.pop_front();
            checks++;
            if (ob_done !== 1'b1 || ob_mis !== e.mis || ob_ill !== e.ill || ob_lat !== e.lat) begin
                fails++; $display("FAIL fault_%0d: done=%b mis=%b ill=%b lat=%0d want 1 %b %b %0d",
                         k, ob_done, ob_mis, ob_ill, ob_lat, e.mis, e.ill, e.lat);
            end
            checks++;
            if (ob_saw_req !== 1'b0 || ob_ld !== e.ld) begin
                fails++; $display("FAIL fault_side_%0d: mem_req_seen=%b ld=%h want 0 %h", k, ob_saw_req, ob_ld, e.ld);
            end
        end
    endtask

    task automatic test_word_ext;
        exp_t e;
        exp_q.push_back('{ld: 64'h00000000F0000001, mis: 1'b0, ill: 1'b0, lat: 3});
        exp_q.push_back('{ld: 64'hFFFFFFFFF0000001, mis: 1'b0, ill: 1'b0, lat: 2});
        issue(1'b0, 3'b110, 64'h4004, 64'h0, 64'hF000000112345678, 1);
        e = exp_q.pop_front();
        checks++;
        if (ob_ld !== e.ld || ob_lat !== e.lat || ob_addr !== 64'h4000) begin
            fails++; $display("FAIL lwu: got %h lat=%0d addr=%h want %h lat=%0d addr=4000", ob_ld, ob_lat, ob_addr, e.ld, e.lat);
        end
        issue(1'b0, 3'b010, 64'h4004, 64'h0, 64'hF000000112345678, 0);
        e = exp_q.pop_front();
        checks++;
        if (ob_ld !== e.ld || ob_lat !== e.lat) begin
            fails++; $display("FAIL lw: got %h lat=%0d want %h lat=%0d", ob_ld, ob_lat, e.ld, e.lat);
        end
    endtask

    task automatic test_reset_mid;
        logic saw_done;
        @(negedge clk);
        bus.i_req_valid = 1'b1; bus.i_is_store = 1'b0; bus.i_funct3 = 3'b011; bus.i_addr = 64'h6000;
        @(posedge clk); #1;
        bus.i_req_valid = 1'b0;
        @(negedge clk);
        checks++;
        if (bus.o_mem_req !== 1'b1) begin
            fails++; $display("FAIL rmid_req: got %b want 1", bus.o_mem_req);
        end
        rst_n = 1'b0; bus.i_mem_ack = 1'b1; bus.i_mem_rdata = 64'h1122334455667788;
        @(negedge clk);
        checks++;
        if (bus.o_mem_req !== 1'b0 || bus.o_done !== 1'b0 || bus.o_load_data !== 64'h0) begin
            fails++; $display("FAIL rmid_abort: req=%b done=%b ld=%h want 0 0 0", bus.o_mem_req, bus.o_done, bus.o_load_data);
        end
        rst_n = 1'b1;
        saw_done = 1'b0;
        @(negedge clk);
        checks++;
        if (bus.o_req_ready !== 1'b1) begin
            fails++; $display("FAIL rmid_ready: got %b want 1", bus.o_req_ready);
        end
        repeat (3) begin
            if (bus.o_done || bus.o_mem_req) saw_done = 1'b1;
            @(negedge clk);
        end
        bus.i_mem_ack = 1'b0;
        checks++;
        if (saw_done !== 1'b0 || bus.o_load_data !== 64'h0) begin
            fails++; $display("FAIL rmid_stray_ack: activity=%b ld=%h want 0 0", saw_done, bus.o_load_data);
        end
    endtask

    task automatic test_back_to_back;
        exp_t e;
        exp_q.push_back('{ld: 64'hFFFFFFFFFFFF8001, mis: 1'b0, ill: 1'b0, lat: 2});
        exp_q.push_back('{ld: 64'h0000000000008001, mis: 1'b0, ill: 1'b0, lat: 2});
        for (int k = 0; k < 2; k++) begin
            issue(1'b0, (k == 0) ? 3'b001 : 3'b101, 64'h5002, 64'h0, 64'h0000000080010000, 0);
            e = exp_q.pop_front();
            checks++;
            if (ob_done !== 1'b1 || ob_ld !== e.ld || ob_lat !== e.lat) begin
                fails++; $display("FAIL b2b_%0d: got %h lat=%0d want %h lat=%0d", k, ob_ld, ob_lat, e.ld, e.lat);
            end
        end
    endtask

    initial begin
        checks = 0;
        fails  = 0;
        test_reset();
        test_ld();
        test_byte_ext();
        test_store_wait();
        test_faults();
        test_word_ext();
        test_reset_mid();
        test_back_to_back();
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout want completion");
        $fatal(1, "watchdog");
    end
endmodule

// File: doc/load_store_unit.md
Name: load_store_unit

Overview:
- Memory stage directly downstream of the ALU in the 64-bit core.
- Takes the ALU result as the effective address, plus the store operand and funct3.
- Performs one load or store per request over a ready/ack data-memory port, with byte-lane alignment and sign/zero extension.
- Returns the extended load value to writeback and flags misaligned or illegal accesses without touching memory.

Parameters:
DATA_WIDTH, 64, data/address width; fixed to 64 in this core, and the 8-lane byte enable relies on it.

Ports:
i_clk  input  1  clock; all state updates on rising edge
i_rst_n  input  1  one clock; reset is synchronous and active-low
i_req_valid  input  1  request present from execute stage
o_req_ready  output  1  unit idle, request accepted this cycle if valid
i_is_store  input  1  1=store, 0=load
i_funct3  input  3  RISC-V size/sign code
i_addr  input  DATA_WIDTH  effective address (ALU o_result)
i_store_data  input  DATA_WIDTH  rs2 value, data in low bytes
o_done  output  1  one-cycle pulse, access finished (success or fault)
o_load_data  output  DATA_WIDTH  extended load result, valid with o_done on loads
o_misaligned  output  1  with o_done: address not size-aligned
o_illegal  output  1  with o_done: funct3 not legal for the direction
o_mem_req  output  1  memory request, held until ack
o_mem_we  output  1  write enable
o_mem_addr  output  DATA_WIDTH  i_addr with bits [2:0] cleared
o_mem_wdata  output  DATA_WIDTH  lane-shifted store data
o_mem_be  output  8  byte enables
i_mem_ack  input  1  memory completed the request; rdata valid same cycle
i_mem_rdata  input  DATA_WIDTH  aligned 8-byte read data

Behaviour:
- **Reset** (i_rst_n low at an edge): state IDLE. All outputs are 0, including o_load_data, o_mem_be, o_mem_addr and o_mem_wdata. This applies mid-transaction: o_mem_req drops the next cycle, any pending ack is ignored, and no o_done is produced.
- **FSM states:** IDLE, MEM, DONE.
- **IDLE:**
  - o_req_ready=1.
  - On i_req_valid, capture is_store, funct3, addr and store_data.
  - Decode the capture:
    - Illegal: load funct3=111, or store funct3[2]=1. Go to DONE with o_illegal=1.
    - Misaligned: half with addr[0]≠0, word with addr[1:0]≠0, or double with addr[2:0]≠0. Go to DONE with o_misaligned=1.
    - Otherwise go to MEM.
  - Illegal takes priority over misaligned.
- **MEM:**
  - o_mem_req=1, o_req_ready=0.
  - Address, we, be and wdata are stable for the whole state.
  - If i_mem_ack is low, stay in MEM with no timeout.
  - On i_mem_ack: for a load, register the extracted and extended data into o_load_data, then go to DONE.
- **DONE:**
  - o_done=1 for exactly one cycle, then IDLE.
  - Fault flags are valid only in DONE and are 0 otherwise.
  - A fault never asserts o_mem_req.
- **Byte enables:**
  - Size mask is 0x01, 0x03, 0x0F or 0xFF for funct3[1:0] = 00, 01, 10, 11.
  - o_mem_be = mask << addr[2:0].
  - o_mem_be = 0 when o_mem_we=0; loads read all 8 bytes.
- **Store data:** o_mem_wdata = store_data << (8*addr[2:0]); bytes outside the be lanes are don't-care but are driven by the shift.
- **Load extraction:**
  - Raw value = i_mem_rdata >> (8*addr[2:0]), truncated to the access size.
  - funct3[2]=0 sign-extends to 64 bits; funct3[2]=1 zero-extends (LBU, LHU, LWU).
- **o_load_data hold:** retains its value until the next successful load. Stores and faults do not change it.
- **Latency:**
  - Accept at edge T, MEM during T..T+1. An ack in the first MEM cycle gives o_done in the following cycle.
  - Minimum 2 cycles from accept to o_done, plus 1 per ack wait cycle. Throughput is one access per 3+ cycles.
- **Stray inputs:** i_req_valid while not ready is ignored; upstream must hold it. i_mem_ack outside MEM is ignored.

Test Plan:
- LD from 0x1000, rdata=0x8877665544332211, ack in first MEM cycle → o_mem_be=0x00, o_mem_addr=0x1000, o_done 2 cycles after accept, o_load_data=0x8877665544332211.
- LB at 0x1003, rdata byte3=0x80 → o_load_data=0xFFFFFFFFFFFFFF80. Same access as LBU → 0x0000000000000080.
- SH at 0x2006, store_data=0xABCD → o_mem_we=1, o_mem_be=0xC0, o_mem_wdata[63:48]=0xABCD, o_mem_addr=0x2000. Ack delayed 3 cycles → req held stable, o_done 5 cycles after accept, o_load_data unchanged.
- LW at 0x3002 → o_done with o_misaligned=1, o_mem_req never asserted. Load funct3=111 at 0x3002 → o_illegal=1 and o_misaligned=0.
- LWU at 0x4004, rdata upper word 0xF0000001 → o_load_data=0x00000000F0000001. LW at the same address → 0xFFFFFFFFF0000001.
- Reset asserted during MEM with ack pending → next cycle o_mem_req=0, state IDLE, o_req_ready=1, no o_done. A later ack is ignored.
